// File: rtl/ftrace_event_gen_if.sv
// Commit-side inputs and reporter-side event outputs of ftrace_event_gen.
// master = commit stage / reporter environment, slave = the event generator.
interface ftrace_event_gen_if #(
  parameter int unsigned RAS_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
);
  logic                         commit_valid;
  logic [31:0]                  commit_pc;
  logic [31:0]                  commit_nextpc;
  logic [31:0]                  commit_inst;
  logic                         evt_ready;
  logic                         func_flag;
  logic                         is_jal;
  logic [31:0]                  pc;
  logic [31:0]                  nextpc;
  logic [5:0]                   rd;
  logic [31:0]                  inst;
  logic [$clog2(RAS_DEPTH):0]   call_depth;
  logic [CNT_W-1:0]             ret_mismatch_cnt;
  logic [CNT_W-1:0]             drop_cnt;
  logic                         underflow;

  modport master (
    output commit_valid, commit_pc, commit_nextpc, commit_inst, evt_ready,
    input  func_flag, is_jal, pc, nextpc, rd, inst,
    input  call_depth, ret_mismatch_cnt, drop_cnt, underflow
  );

  modport slave (
    input  commit_valid, commit_pc, commit_nextpc, commit_inst, evt_ready,
    output func_flag, is_jal, pc, nextpc, rd, inst,
    output call_depth, ret_mismatch_cnt, drop_cnt, underflow
  );
endinterface

// File: rtl/ftrace_event_gen.sv
// Classifies committed RISC-V calls/returns, tracks them on a shadow return
// stack, and queues call/ret events for the function-trace reporter.
module ftrace_event_gen #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAS_DEPTH  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clock,
  input logic             reset,
  ftrace_event_gen_if.slave bus
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned RAW = $clog2(RAS_DEPTH);
  localparam int unsigned DW  = RAW + 1;

  typedef struct packed {
    logic        is_jal;
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [5:0]  rd;
    logic [31:0] inst;
  } evt_t;

  // Decode
  logic [6:0] opc;
  logic [4:0] rdf;
  logic [4:0] rs1;
  logic       is_call;
  logic       is_ret;
  logic       evt;
  evt_t       new_evt;

  assign opc = bus.commit_inst[6:0];
  assign rdf = bus.commit_inst[11:7];
  assign rs1 = bus.commit_inst[19:15];

  assign is_call = bus.commit_valid && (opc == 7'b1101111 || opc == 7'b1100111) &&
                   (rdf == 5'd1 || rdf == 5'd5);
  assign is_ret  = bus.commit_valid && opc == 7'b1100111 && rdf == 5'd0 &&
                   (rs1 == 5'd1 || rs1 == 5'd5) && bus.commit_inst[31:20] == 12'd0;
  assign evt     = is_call || is_ret;

  assign new_evt = '{is_jal: is_call,
                     pc:     bus.commit_pc,
                     nextpc: bus.commit_nextpc,
                     rd:     {1'b0, rdf},
                     inst:   bus.commit_inst};

  // Event FIFO; pointers carry an extra wrap bit to tell full from empty
  evt_t           fifo_q [FIFO_DEPTH];
  logic [FAW:0]   wptr_q;
  logic [FAW:0]   rptr_q;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           drop;
  evt_t           head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
  assign pop   = !empty && bus.evt_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;
  assign head  = fifo_q[rptr_q[FAW-1:0]];

  // FIFO storage write; contents are don't-care while empty
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wptr_q[FAW-1:0]] <= new_evt;
    end
  end

  // FIFO pointer update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Shadow return-address stack: circular, tos_q is the next slot to write
  logic [31:0]      ras_q [RAS_DEPTH];
  logic [RAW-1:0]   tos_q;
  logic [RAW-1:0]   top_idx;
  logic [DW-1:0]    depth_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             underflow_q;
  logic             ret_hit;
  logic             mismatch;

  assign top_idx  = tos_q - 1'b1;
  assign ret_hit  = is_ret && (depth_q != '0);
  assign mismatch = ret_hit && (bus.commit_nextpc != ras_q[top_idx]);

  // Return-address push; at saturation this overwrites the oldest entry
  always_ff @(posedge clock) begin
    if (is_call) begin
      ras_q[tos_q] <= bus.commit_pc + 32'd4;
    end
  end

  // Stack pointer, depth, counters and sticky underflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tos_q       <= '0;
      depth_q     <= '0;
      mis_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (is_call) begin
        tos_q <= tos_q + 1'b1;
        if (depth_q != DW'(RAS_DEPTH)) depth_q <= depth_q + 1'b1;
      end else if (ret_hit) begin
        tos_q   <= top_idx;
        depth_q <= depth_q - 1'b1;
        if (mismatch && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
      end else if (is_ret) begin
        underflow_q <= 1'b1;
      end
      if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // Outputs follow the FIFO head, forced to zero while empty so reset clears them at once
  assign bus.func_flag        = !empty;
  assign bus.is_jal           = empty ? 1'b0  : head.is_jal;
  assign bus.pc               = empty ? 32'd0 : head.pc;
  assign bus.nextpc           = empty ? 32'd0 : head.nextpc;
  assign bus.rd               = empty ? 6'd0  : head.rd;
  assign bus.inst             = empty ? 32'd0 : head.inst;
  assign bus.call_depth       = depth_q;
  assign bus.ret_mismatch_cnt = mis_cnt_q;
  assign bus.drop_cnt         = drop_cnt_q;
  assign bus.underflow        = underflow_q;

endmodule
